sad_select_ctrl: RTL and testbench

SAD_SELECT_CTRL -- requirements
Module: sad_select_ctrl

---
 rtl/sad_select_ctrl.sv | 80 ++++++++
 tb/tb_sad_select_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sad_select_ctrl.sv
// sad_select_ctrl: picks the min or max of eight captured 32-bit SAD values over a
// fixed 11-cycle pass and writes the winner to register DEST_REG.
module sad_select_ctrl #(
    parameter logic [4:0] DEST_REG = 5'd31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         small_big,
    input  logic         allow_find,
    input  logic         abort,
    input  logic [255:0] sad_in,
    output logic         busy,
    output logic         stall,
    output logic         wr_en,
    output logic [4:0]   wr_addr,
    output logic [31:0]  wr_data,
    output logic [31:0]  best_value,
    output logic [2:0]   best_index,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, DONE} state_t;

    state_t            state, state_nx;
    logic [7:0][31:0]  sad_buf;
    logic [2:0]        cnt;
    logic              mode;
    logic [31:0]       cur;
    logic              better;

    // strict compares so ties keep the earlier (lower) index
    assign cur    = sad_buf[cnt];
    assign better = mode ? (cur > best_value) : (cur < best_value);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && allow_find) ? LOAD : IDLE;
            LOAD:    state_nx = abort ? IDLE : SCAN;
            SCAN:    state_nx = abort ? IDLE : (cnt == 3'd7 ? WRITE : SCAN);
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy    = state != IDLE;
        stall   = busy;
        wr_en   = state == WRITE;
        wr_addr = wr_en ? DEST_REG : 5'd0;
        wr_data = wr_en ? best_value : 32'd0;
        done    = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sad_buf    <= '0;
            cnt        <= 3'd0;
            mode       <= 1'b0;
            best_value <= 32'd0;
            best_index <= 3'd0;
        end else begin
            state <= state_nx;
            if (state == LOAD && !abort) begin
                sad_buf    <= sad_in;
                mode       <= small_big;
                best_value <= sad_in[31:0];
                best_index <= 3'd0;
                cnt        <= 3'd1;
            end
            if (state == SCAN && !abort) begin
                if (better) begin
                    best_value <= cur;
                    best_index <= cnt;
                end
                if (cnt != 3'd7)
                    cnt <= cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_sad_select_ctrl.sv
// tb_sad_select_ctrl: directed passes; a monitor pops expected writes from a scoreboard.
module tb_sad_select_ctrl;
    logic         clk = 0, rst = 0, start = 0, small_big = 0, allow_find = 0, abort = 0;
    logic [255:0] sad_in = '0;
    logic         busy, stall, wr_en, done;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data, best_value;
    logic [2:0]   best_index;

    sad_select_ctrl #(.DEST_REG(5'd31)) dut (
        .clk(clk), .rst(rst), .start(start), .small_big(small_big),
        .allow_find(allow_find), .abort(abort), .sad_in(sad_in),
        .busy(busy), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .best_value(best_value), .best_index(best_index), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    logic [39:0] sb_q[$];
    logic [39:0] cur_exp = '0;
    logic        have_exp = 0;

    localparam logic [255:0] D0 = {32'd80, 32'd70, 32'd60, 32'd5, 32'd90, 32'd12, 32'd33, 32'd40};
    localparam logic [255:0] D1 = {32'd3, 32'd100, 32'd3, 32'd50, 32'd200, 32'd1, 32'd1, 32'd9};
    localparam logic [255:0] D7 = {8{32'd7}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (sb_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                cur_exp = sb_q.pop_front();
                check("wr_addr", {27'd0, wr_addr}, {27'd0, cur_exp[39:35]});
                check("wr_data", wr_data, cur_exp[34:3]);
                have_exp = 1;
            end
        end
        if (done) begin
            if (!have_exp) check("unexpected_done", 1, 0);
            else begin
                check("best_index", {29'd0, best_index}, {29'd0, cur_exp[2:0]});
                check("best_value", best_value, cur_exp[34:3]);
                have_exp = 0;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_stall"}, {31'd0, stall}, 0);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_wr_addr"}, {27'd0, wr_addr}, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_best_value"}, best_value, 0);
        check({tag, "_best_index"}, {29'd0, best_index}, 0);
    endtask

    // Entered just after a rising edge; that cycle is cycle 0 of the pass.
    task automatic run(input logic [255:0] d, input logic sb, input int abort_at,
                       input int restart_at, input logic chg, input int exp_wr,
                       input int exp_done, input int exp_cnt, input int exp_idle, input string tag);
        int wc = -1, dc = -1, cnt = 0, ic = -1;
        sad_in = d; small_big = sb; allow_find = 1;
        for (int c = 0; c <= 13; c++) begin
            start = (c == 0) || (c == restart_at);
            abort = (c == abort_at);
            if (chg && c == 3) begin
                sad_in = ~d;
                small_big = ~sb;
            end
            @(negedge clk);
            if (c == 1) check({tag, "_busy_c1"}, {31'd0, busy}, 1);
            if (wr_en) begin cnt++; wc = c; end
            if (done) dc = c;
            if (c > 0 && !busy && ic < 0) ic = c;
            @(posedge clk); #1;
        end
        start = 0; abort = 0;
        check({tag, "_wr_cycle"}, wc, exp_wr);
        check({tag, "_done_cycle"}, dc, exp_done);
        check({tag, "_wr_count"}, cnt, exp_cnt);
        check({tag, "_idle_cycle"}, ic, exp_idle);
    endtask

    initial begin
        #1 rst = 1;
        #1 check_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(posedge clk); #1;

        sb_q.push_back({5'd31, 32'd5, 3'd4});
        run(D0, 0, -1, -1, 0, 9, 10, 1, 11, "min");
        sb_q.push_back({5'd31, 32'd90, 3'd3});
        run(D0, 1, -1, -1, 1, 9, 10, 1, 11, "max_chg");
        sb_q.push_back({5'd31, 32'd7, 3'd0});
        run(D7, 0, -1, -1, 0, 9, 10, 1, 11, "tie_min");
        sb_q.push_back({5'd31, 32'd7, 3'd0});
        run(D7, 1, -1, -1, 0, 9, 10, 1, 11, "tie_max");
        sb_q.push_back({5'd31, 32'd1, 3'd1});
        run(D1, 0, 0, -1, 0, 9, 10, 1, 11, "abort_start");
        sb_q.push_back({5'd31, 32'd200, 3'd3});
        run(D1, 1, 9, -1, 0, 9, 10, 1, 11, "abort_write");
        sb_q.push_back({5'd31, 32'd5, 3'd4});
        run(D0, 0, -1, 4, 0, 9, 10, 1, 11, "restart");
        run(D0, 0, 5, -1, 0, -1, -1, 0, 6, "abort_scan");

        allow_find = 0; start = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_allow_busy", {31'd0, busy}, 0);
            @(posedge clk); #1;
        end
        start = 0;

        sad_in = D0; small_big = 0; allow_find = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        #1 check_zero("mid_reset");
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        sb_q.push_back({5'd31, 32'd5, 3'd4});
        run(D0, 0, -1, -1, 0, 9, 10, 1, 11, "after_reset");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
